// File: rtl/reg_file.sv
// MIPS 32x32 register file: two combinational read ports, one synchronous write port, r0 hardwired to 0.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [ADDR_WIDTH-1:0] addr3,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  regWrite,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic [DATA_WIDTH-1:0] dout2
);
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic                            wr_en;

  assign wr_en = regWrite && (addr3 != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[addr3] = din;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '0;
    else      regs_q <= regs_d;
  end

  // Reads are masked during reset so forwarded din cannot leak out while rst is low.
  always_comb begin
    dout1 = regs_q[addr1];
    dout2 = regs_q[addr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (addr1 == addr3)) dout1 = din;
    if (wr_en && (addr2 == addr3)) dout2 = din;
`else
`endif
    if (!rst || addr1 == '0) dout1 = '0;
    if (!rst || addr2 == '0) dout2 = '0;
  end
endmodule

// File: tb/tb_reg_file.sv
// Randomized self-checking bench for reg_file against an array-based reference model.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  addr1 = '0, addr2 = '0, addr3 = '0;
  logic [31:0] din = '0;
  logic        regWrite = 1'b0;
  logic [31:0] dout1, dout2;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];

  reg_file dut (
    .clk(clk), .rst(rst), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .din(din), .regWrite(regWrite), .dout1(dout1), .dout2(dout2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (regWrite && addr3 != 0 && a == addr3) return din;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Advance one rising edge, applying the architectural write rule to the model.
  task automatic edge_step();
    @(posedge clk);
    if (rst && regWrite && addr3 != 0) model[addr3] = din;
    #1;
  endtask

  task automatic check_ports(input string tag);
    chk({tag, "_d1"}, dout1, exp_rd(addr1));
    chk({tag, "_d2"}, dout2, exp_rd(addr2));
  endtask

  initial begin
    clear_model();
    // Reset held: writes blocked and outputs zero even with a pending write.
    regWrite = 1'b1; addr3 = 5'd7; din = 32'hCAFE_F00D; addr1 = 5'd7; addr2 = 5'd7;
    #30;
    chk("rst_hold_d1", dout1, 32'h0);
    chk("rst_hold_d2", dout2, 32'h0);
    #70;
    regWrite = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      addr1 = i[4:0];
      #1;
      chk($sformatf("rst_r%0d", i), dout1, 32'h0);
    end

    // Write to r0 is discarded.
    @(negedge clk);
    regWrite = 1'b1; addr3 = 5'd0; din = 32'h1234_5678;
    edge_step();
    regWrite = 1'b0; addr1 = 5'd0;
    #1 chk("r0_discard", dout1, 32'h0);

    // Basic write and read on port 2.
    @(negedge clk);
    regWrite = 1'b1; addr3 = 5'd1; din = 32'h1111_1111;
    edge_step();
    regWrite = 1'b0; addr2 = 5'd1; addr1 = 5'd0;
    #1;
    chk("wr_r1_d2", dout2, 32'h1111_1111);
    chk("wr_r1_d1_r0", dout1, 32'h0);

    // regWrite low: no change.
    @(negedge clk);
    regWrite = 1'b0; addr3 = 5'd2; din = 32'hDEAD_BEEF;
    edge_step();
    addr1 = 5'd2;
    #1 chk("no_we_r2", dout1, 32'h0);

    // Same-cycle read of register being written, then after the edge.
    @(negedge clk);
    regWrite = 1'b1; addr3 = 5'd5; din = 32'h0000_00FF; addr1 = 5'd5; addr2 = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre_d1", dout1, 32'h0000_00FF);
`else
    chk("byp_pre_d1", dout1, 32'h0);
`endif
    chk("byp_pre_d2_model", dout2, exp_rd(5'd5));
    edge_step();
    regWrite = 1'b0;
    #1;
    chk("byp_post_d1", dout1, 32'h0000_00FF);
    chk("byp_post_d2", dout2, 32'h0000_00FF);

    // Async reset between edges clears r31 immediately.
    @(negedge clk);
    regWrite = 1'b1; addr3 = 5'd31; din = 32'hA5A5_A5A5;
    edge_step();
    regWrite = 1'b0; addr1 = 5'd31;
    #1 chk("r31_written", dout1, 32'hA5A5_A5A5);
    #1 rst = 1'b0;
    #1 chk("async_rst_r31", dout1, 32'h0);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    #1 chk("after_rst_r31", dout1, 32'h0);
    chk("after_rst_r1", exp_rd(5'd1), 32'h0);
    addr2 = 5'd1;
    #1 chk("after_rst_r1_dut", dout2, 32'h0);

    // Randomized traffic, with occasional mid-run resets.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      regWrite = ($urandom_range(0, 3) != 0);
      addr3 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      din   = $urandom;
      addr1 = ($urandom_range(0, 2) == 0) ? addr3 : 5'($urandom_range(0, 7));
      addr2 = ($urandom_range(0, 2) == 0) ? addr3 : 5'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        clear_model();
        #1 check_ports("rnd_rst");
        edge_step();
        check_ports("rnd_rst_edge");
        @(negedge clk);
        rst = 1'b1;
        regWrite = 1'b0;
      end
      #1 check_ports("rnd_pre");
      edge_step();
      check_ports("rnd_post");
    end

    // Full sweep of both ports against the model.
    regWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addr1 = i[4:0];
      addr2 = 5'(31 - i);
      #1 check_ports($sformatf("sweep_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
